// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB I2C command sequencer.
//  - register offsets (paddr[3:2] index)
//  - STATUS / CTRL bit positions
//  - sequencer FSM state type
//  - cmd_t: one queued I2C byte transaction, laid out to match CMD[15:0]
package apb_i2c_pkg;

  localparam logic [1:0] REG_CMD    = 2'd0;  // 0x0
  localparam logic [1:0] REG_STATUS = 2'd1;  // 0x4
  localparam logic [1:0] REG_RXDATA = 2'd2;  // 0x8
  localparam logic [1:0] REG_CTRL   = 2'd3;  // 0xC

  localparam int STAT_BUSY     = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_RX_VALID = 3;
  localparam int STAT_TMO_ERR  = 4;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    BUSY    = 3'd2,
    DONE    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  // Packed MSB-first so that a cast of CMD[15:0] gives the fields directly.
  typedef struct packed {
    logic [7:0] wdata;
    logic       rw;
    logic [6:0] addr;
  } cmd_t;

endpackage

// File: rtl/apb_i2c_sequencer_if.sv
// APB bus bundle for the I2C sequencer.
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) and
// completes in the following access cycle (psel=1, penable=1). pready is
// always 1, so every access cycle completes; prdata and pslverr are valid
// during the access cycle.
//  master modport: drives psel/penable/pwrite/paddr/pwdata
//  slave modport : drives prdata/pready/pslverr
interface apb_i2c_sequencer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_i2c_cmd_fifo.sv
// Synchronous command FIFO for the I2C sequencer.
// Ports:
//  clk, rst_n        clock, asynchronous active-low reset
//  push, push_data   write one cmd_t (ignored when full)
//  pop               discard the head entry (ignored when empty)
//  head              entry at the read pointer (first-word fall-through)
//  full, empty       status from the registered pointers
// Pointers carry one extra wrap bit to tell full from empty; DEPTH must be a
// power of two.
module apb_i2c_cmd_fifo
  import apb_i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/apb_i2c_sequencer.sv
// APB slave that queues I2C byte commands and sequences one i2c_master.
// Registers (paddr[3:2]): CMD (W, push), STATUS (R, W1C [3],[4]),
// RXDATA (R, read clears rx_valid), CTRL (RW, [0] run, [1] irq_en).
// Ports:
//  clk, presetn          clock, asynchronous active-low reset
//  apb                   APB slave bundle (zero wait states)
//  i2c_reset/enable/...  request side of the i2c_master handshake
//  i2c_data_out, i2c_ready  from i2c_master, synchronised internally
//  dbg_state             current sequencer state
//  irq                   only when APB_I2C_SEQ_IRQ_EN is defined
// prdata/pslverr are registered in the setup cycle so they are stable for
// the whole access cycle; the CMD push in the access cycle follows that same
// registered error decision so a reported drop is always a real drop.
module apb_i2c_sequencer
  import apb_i2c_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 1024,
  parameter int RST_CYCLES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       presetn,
  apb_i2c_sequencer_if.slave apb,
  output logic       i2c_reset,
  output logic       i2c_enable,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_data_in,
  input  logic [7:0] i2c_data_out,
  input  logic       i2c_ready,
  output state_t     dbg_state
`ifdef APB_I2C_SEQ_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  // ---------------- synchronisers ----------------
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   rdy_s;
  logic [7:0]             data_s;

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      rdy_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      rdy_sync[0]  <= i2c_ready;
      data_sync[0] <= i2c_data_out;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rdy_sync[i]  <= rdy_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign rdy_s  = rdy_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // ---------------- command FIFO ----------------
  cmd_t fifo_head;
  cmd_t push_cmd;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic cmd_push;

  assign push_cmd = apb.pwdata[15:0];

  apb_i2c_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (presetn),
    .push      (cmd_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- APB register file ----------------
  logic        setup_ph;
  logic        access_ph;
  logic [1:0]  reg_sel;
  logic        err_calc;
  logic        err_q;
  logic [31:0] prdata_q;
  logic [31:0] rd_val;
  logic        run;
  logic        irq_en;
  logic        rx_valid;
  logic        timeout_err;
  logic [7:0]  rxdata;
  logic        busy;
  logic        status_wr;
  logic        rxdata_rd;
  logic        set_rx;
  logic        set_tmo;
  logic        unused_bits;

  assign setup_ph  = apb.psel & ~apb.penable;
  assign access_ph = apb.psel & apb.penable;
  assign reg_sel   = apb.paddr[3:2];
  assign busy      = (dbg_state != IDLE);

  assign err_calc  = apb.pwrite & (((reg_sel == REG_CMD) & fifo_full) |
                                   (reg_sel == REG_RXDATA) |
                                   (reg_sel == REG_STATUS));
  assign cmd_push  = access_ph & apb.pwrite & (reg_sel == REG_CMD) & ~err_q;
  assign status_wr = access_ph & apb.pwrite & (reg_sel == REG_STATUS);
  assign rxdata_rd = access_ph & ~apb.pwrite & (reg_sel == REG_RXDATA);

  assign unused_bits = ^{apb.pwdata[31:16], apb.paddr[1:0]};

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_val[STAT_BUSY]     = busy;
        rd_val[STAT_FULL]     = fifo_full;
        rd_val[STAT_EMPTY]    = fifo_empty;
        rd_val[STAT_RX_VALID] = rx_valid;
        rd_val[STAT_TMO_ERR]  = timeout_err;
      end
      REG_RXDATA: rd_val[7:0] = rxdata;
      REG_CTRL: begin
        rd_val[CTRL_RUN]    = run;
        rd_val[CTRL_IRQ_EN] = irq_en;
      end
      default: rd_val = '0;  // CMD reads as zero
    endcase
  end

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      prdata_q    <= '0;
      err_q       <= 1'b0;
      run         <= 1'b0;
      rx_valid    <= 1'b0;
      timeout_err <= 1'b0;
      rxdata      <= '0;
    end else begin
      err_q <= setup_ph & err_calc;
      if (setup_ph) prdata_q <= apb.pwrite ? 32'd0 : rd_val;
      if (access_ph & apb.pwrite & (reg_sel == REG_CTRL)) run <= apb.pwdata[CTRL_RUN];
      if (set_rx) rxdata <= data_s;
      // A hardware set in the same cycle as a clear wins.
      if (set_rx)
        rx_valid <= 1'b1;
      else if (rxdata_rd | (status_wr & apb.pwdata[STAT_RX_VALID]))
        rx_valid <= 1'b0;
      if (set_tmo)
        timeout_err <= 1'b1;
      else if (status_wr & apb.pwdata[STAT_TMO_ERR])
        timeout_err <= 1'b0;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pslverr = err_q;
  assign apb.pready  = 1'b1;

`ifdef APB_I2C_SEQ_IRQ_EN
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (access_ph & apb.pwrite & (reg_sel == REG_CTRL)) irq_en <= apb.pwdata[CTRL_IRQ_EN];
      irq <= irq_en & (rx_valid | timeout_err | (fifo_empty & ~busy));
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // ---------------- sequencer FSM ----------------
  state_t        state, state_d;
  logic [TW-1:0] tmo, tmo_d;
  logic [RW-1:0] rst_cnt, rst_cnt_d;
  cmd_t          cur_cmd, cmd_d;
  logic          enable_d;
  logic          reset_d;

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state      <= RECOVER;
      tmo        <= '0;
      rst_cnt    <= RW'(RST_CYCLES);
      cur_cmd    <= '0;
      i2c_enable <= 1'b0;
      i2c_reset  <= 1'b1;
    end else begin
      state      <= state_d;
      tmo        <= tmo_d;
      rst_cnt    <= rst_cnt_d;
      cur_cmd    <= cmd_d;
      i2c_enable <= enable_d;
      i2c_reset  <= reset_d;
    end
  end

  always_comb begin
    state_d   = state;
    tmo_d     = tmo;
    rst_cnt_d = rst_cnt;
    cmd_d     = cur_cmd;
    enable_d  = i2c_enable;
    fifo_pop  = 1'b0;
    set_rx    = 1'b0;
    set_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (run && !fifo_empty && rdy_s) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          enable_d = 1'b1;
          tmo_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Master drops ready once it has taken the request.
        if (!rdy_s) begin
          enable_d = 1'b0;
          tmo_d    = '0;
          state_d  = BUSY;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          enable_d  = 1'b0;
          rst_cnt_d = RW'(RST_CYCLES);
          state_d   = RECOVER;
        end else begin
          tmo_d = tmo + TW'(1);
        end
      end
      BUSY: begin
        if (rdy_s) begin
          state_d = DONE;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          set_tmo   = 1'b1;
          rst_cnt_d = RW'(RST_CYCLES);
          state_d   = RECOVER;
        end else begin
          tmo_d = tmo + TW'(1);
        end
      end
      DONE: begin
        set_rx  = cur_cmd.rw;
        state_d = IDLE;
      end
      RECOVER: begin
        // The aborted command is dropped; queued commands stay in the FIFO.
        cmd_d    = '0;
        enable_d = 1'b0;
        if (rst_cnt <= RW'(1)) state_d = IDLE;
        else rst_cnt_d = rst_cnt - RW'(1);
      end
      default: begin
        enable_d  = 1'b0;
        rst_cnt_d = RW'(RST_CYCLES);
        state_d   = RECOVER;
      end
    endcase
    reset_d = (state_d == RECOVER);
  end

  assign i2c_addr    = cur_cmd.addr;
  assign i2c_rw      = cur_cmd.rw;
  assign i2c_data_in = cur_cmd.wdata;
  assign dbg_state   = state;

endmodule

// File: tb/tb_apb_i2c_sequencer.sv
// Testbench for apb_i2c_sequencer: APB driver tasks, a behavioural
// i2c_master model, an expected-dispatch queue and APB response queues
// checked by a monitor, and a final report.
module tb_apb_i2c_sequencer;
  import apb_i2c_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int RSTC  = 8;
  localparam int SYNC  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic presetn = 1'b0;
  always #5 clk = ~clk;

  apb_i2c_sequencer_if apb();
  logic       i2c_reset, i2c_enable, i2c_rw, i2c_ready;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data_in, i2c_data_out;
  state_t     dbg_state;
`ifdef APB_I2C_SEQ_IRQ_EN
  logic       irq;
`endif

  apb_i2c_sequencer #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .RST_CYCLES(RSTC), .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .presetn      (presetn),
    .apb          (apb),
    .i2c_reset    (i2c_reset),
    .i2c_enable   (i2c_enable),
    .i2c_addr     (i2c_addr),
    .i2c_rw       (i2c_rw),
    .i2c_data_in  (i2c_data_in),
    .i2c_data_out (i2c_data_out),
    .i2c_ready    (i2c_ready),
    .dbg_state    (dbg_state)
`ifdef APB_I2C_SEQ_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];     // commands accepted, in dispatch order {wdata,rw,addr}
  logic [31:0] rd_exp_q[$];  // expected prdata per APB read
  logic        err_exp_q[$]; // expected pslverr per APB access
  logic        en_prev = 1'b0;

  // reference model of the register-visible state
  logic       m_rx_valid = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic       m_tmo = 1'b0;
  logic       hang_mode = 1'b0;
  logic       hold_long = 1'b0;
  logic       force_rd = 1'b0;
  logic [7:0] force_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen or unexpected at %0t", name, $time);
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[STAT_FULL]     = (exp_q.size() == DEPTH);
    s[STAT_EMPTY]    = (exp_q.size() == 0);
    s[STAT_RX_VALID] = m_rx_valid;
    s[STAT_TMO_ERR]  = m_tmo;
    return s;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!presetn) begin
      en_prev = 1'b0;
    end else begin
      if (apb.psel && apb.penable) begin
        if (err_exp_q.size() == 0) fail_now("apb_unexpected");
        else check("pslverr", 32'(apb.pslverr), 32'(err_exp_q.pop_front()));
        if (!apb.pwrite) begin
          if (rd_exp_q.size() == 0) fail_now("rd_unexpected");
          else check("prdata", apb.prdata, rd_exp_q.pop_front());
        end
      end
      if (i2c_enable && !en_prev) begin
        if (exp_q.size() == 0) fail_now("dispatch_unexpected");
        else check("dispatch", 32'({i2c_data_in, i2c_rw, i2c_addr}), 32'(exp_q.pop_front()));
      end
      en_prev = i2c_enable;
    end
  end

  // ---------------- i2c_master model ----------------
  task automatic serve();
    logic rw;
    logic aborted;
    logic [7:0] b;
    int d;
    rw = i2c_rw;
    aborted = 1'b0;
    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
      if (i2c_reset) aborted = 1'b1;
    end
    if (!aborted) begin
      i2c_ready = 1'b0;
      for (int i = 0; i < 50 && i2c_enable && !i2c_reset; i++) begin @(posedge clk); #1; end
      if (hang_mode) d = 8 * TMO;
      else d = hold_long ? 40 : $urandom_range(1, 8);
      for (int i = 0; i < d && !i2c_reset; i++) begin @(posedge clk); #1; end
      if (i2c_reset) aborted = 1'b1;
    end
    if (!aborted && rw) begin
      b = force_rd ? force_val : 8'($urandom);
      i2c_data_out = b;
      m_last = b;
      m_rx_valid = 1'b1;
    end
    i2c_ready = 1'b1;
  endtask

  initial begin : master_model
    i2c_ready = 1'b1;
    i2c_data_out = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (i2c_reset) i2c_ready = 1'b1;
      else if (i2c_enable && i2c_ready) serve();
    end
  end

  // ---------------- APB driver tasks ----------------
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic exp_err);
    err_exp_q.push_back(exp_err);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, input logic [31:0] exp);
    rd_exp_q.push_back(exp);
    err_exp_q.push_back(1'b0);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    if (a[3:2] == REG_RXDATA) m_rx_valid = 1'b0;
  endtask

  task automatic cmd_push(input logic [6:0] addr, input logic rw, input logic [7:0] wd);
    logic full_now;
    full_now = (exp_q.size() == DEPTH);
    if (!full_now) exp_q.push_back({wd, rw, addr});
    apb_write(4'h0, {16'h0, wd, rw, addr}, full_now);
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && dbg_state == IDLE && i2c_ready && !i2c_enable) break;
    end
    if (n == 3000) fail_now(name);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic count_reset_pulse(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!i2c_reset) break;
      n++;
    end
    check(name, n, RSTC);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    presetn = 1'b0;
    exp_q.delete();
    m_rx_valid = 1'b0;
    m_last = 8'h00;
    m_tmo = 1'b0;
    #1;
    check("rst_i2c_reset", 32'(i2c_reset), 32'd1);
    check("rst_outputs", {i2c_enable, i2c_rw, i2c_addr, i2c_data_in}, 32'd0);
    check("rst_apb", {apb.prdata[30:0], apb.pslverr}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(RECOVER));
    repeat (3) @(posedge clk);
    #1;
    presetn = 1'b1;
    count_reset_pulse("rst_pulse_len");
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;

    do_reset();
    apb_read(4'h4, exp_status());
    apb_read(4'hC, 32'd0);

    // single write dispatch
    apb_write(4'hC, 32'h1, 1'b0);
    cmd_push(7'h50, 1'b0, 8'hAB);
    wait_idle("idle_write");
    apb_read(4'h4, exp_status());

    // single read with a known byte
    force_rd = 1'b1; force_val = 8'h5A;
    cmd_push(7'h21, 1'b1, 8'h00);
    wait_idle("idle_read");
    force_rd = 1'b0;
    apb_read(4'h4, exp_status());
    apb_read(4'h8, {24'h0, m_last});
    apb_read(4'h4, exp_status());

    // fill with run=0, overflow, illegal accesses, then drain in order
    apb_write(4'hC, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cmd_push(7'($urandom), 1'($urandom), 8'($urandom));
    apb_read(4'h4, exp_status());
    cmd_push(7'h7F, 1'b0, 8'hEE);
    apb_write(4'h8, 32'h12, 1'b1);
    apb_write(4'h4, 32'h0, 1'b1);
    apb_read(4'h0, 32'd0);
    apb_read(4'h4, exp_status());
    apb_write(4'hC, 32'h1, 1'b0);
    wait_idle("idle_drain");
    apb_read(4'h4, exp_status());

    // random traffic while running
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      for (n = 0; n < 500 && exp_q.size() >= DEPTH; n++) @(posedge clk);
      cmd_push(7'($urandom), 1'($urandom), 8'($urandom));
    end
    wait_idle("idle_random");
    apb_read(4'h4, exp_status());
    apb_read(4'h8, {24'h0, m_last});
    apb_read(4'h4, exp_status());

    // hung master: timeout, recovery pulse, next command still dispatches
    hang_mode = 1'b1;
    cmd_push(7'h33, 1'b0, 8'h44);
    for (n = 0; n < 4 * TMO; n++) begin
      @(negedge clk);
      if (i2c_reset) break;
    end
    if (n < TMO || n > TMO + 20) fail_now("timeout_latency");
    else check("timeout_latency", 32'd1, 32'(i2c_reset));
    m_tmo = 1'b1;
    hang_mode = 1'b0;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!i2c_reset) break;
      n++;
    end
    check("recover_pulse_len", n, RSTC);
    apb_read(4'h4, exp_status());
    cmd_push(7'h11, 1'b0, 8'h22);
    wait_idle("idle_after_recover");
    apb_write(4'h4, 32'h10, 1'b1);
    m_tmo = 1'b0;
    apb_read(4'h4, exp_status());

    // CTRL[1] only exists with the irq option
`ifdef APB_I2C_SEQ_IRQ_EN
    apb_write(4'hC, 32'h3, 1'b0);
    apb_read(4'hC, 32'h3);
    repeat (3) @(negedge clk);
    check("irq_idle_empty", 32'(irq), 32'd1);
    apb_write(4'hC, 32'h1, 1'b0);
    repeat (3) @(negedge clk);
    check("irq_masked", 32'(irq), 32'd0);
`else
    apb_write(4'hC, 32'h3, 1'b0);
    apb_read(4'hC, 32'h1);
`endif

    // reset in the middle of a transaction, with another command queued
    hold_long = 1'b1;
    cmd_push(7'h0A, 1'b0, 8'h55);
    for (n = 0; n < 60 && dbg_state != BUSY; n++) @(negedge clk);
    if (n == 60) fail_now("reach_busy");
    cmd_push(7'h0B, 1'b1, 8'h66);
    do_reset();
    hold_long = 1'b0;
    apb_read(4'h4, exp_status());
    apb_read(4'hC, 32'd0);
    apb_read(4'h8, 32'd0);

    repeat (5) @(posedge clk);
    check("leftover_dispatch", exp_q.size(), 32'd0);
    check("leftover_apb", rd_exp_q.size() + err_exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
